// File: rtl/uart_baud_pkg.sv
// Shared constants for the fractional UART baud generator: oversampling modes,
// default divisor widths and the per-mode sub-sample terminal/half counts.
package uart_baud_pkg;

    localparam int DL_W_DEF   = 16;
    localparam int FRAC_W_DEF = 4;

    localparam logic OSR_16 = 1'b0;
    localparam logic OSR_8  = 1'b1;

    localparam logic [3:0] SUB_TERM_16 = 4'd15;
    localparam logic [3:0] SUB_HALF_16 = 4'd7;
    localparam logic [3:0] SUB_TERM_8  = 4'd7;
    localparam logic [3:0] SUB_HALF_8  = 4'd3;

    function automatic logic [3:0] sub_term(input logic osr);
        return (osr == OSR_8) ? SUB_TERM_8 : SUB_TERM_16;
    endfunction

    function automatic logic [3:0] sub_half(input logic osr);
        return (osr == OSR_8) ? SUB_HALF_8 : SUB_HALF_16;
    endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional divisor accumulator; carry is the overflow of acc+dlf for the current step.
// Latency: acc updates one cycle after step; clr has priority; no backpressure.
module uart_frac_acc
    import uart_baud_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              clr,
    input  logic              step,
    input  logic [FRAC_W-1:0] dlf,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, dlf};
    assign carry = sum[FRAC_W];

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/uart_frac_baudgen.sv
// Fractional-N UART baud generator: sample ticks every DL or DL+1 cycles, plus mid-bit and end-of-bit ticks.
// Latency: all outputs registered, first tick dl_i cycles after load_i; free-running, no backpressure.
module uart_frac_baudgen
    import uart_baud_pkg::*;
#(
    parameter int DL_W   = DL_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic [DL_W-1:0]   dl_i,
    input  logic [FRAC_W-1:0] dlf_i,
    input  logic              osr_i,
    input  logic              load_i,
    input  logic              sync_i,
    output logic              enable_o,
    output logic              half_tick_o,
    output logic              bit_tick_o,
    output logic              div_active_o
);

    localparam logic [DL_W-1:0] ONE = DL_W'(1);

    logic [DL_W-1:0]   dl_q;
    logic [FRAC_W-1:0] dlf_q;
    logic              osr_q;
    logic [DL_W-1:0]   cnt;
    logic [3:0]        subcnt;
    logic              carry;
    logic              tick_due;
    logic [3:0]        term;
    logic [3:0]        half;

    // A load aborts whatever period is in flight, including one due this cycle.
    assign tick_due = (dl_q != '0) && (cnt == '0) && !load_i;
    assign term     = sub_term(osr_q);
    assign half     = sub_half(osr_q);

    uart_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_acc (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .clr      (load_i),
        .step     (tick_due),
        .dlf      (dlf_q),
        .carry    (carry)
    );

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dl_q         <= '0;
            dlf_q        <= '0;
            osr_q        <= OSR_16;
            cnt          <= '0;
            subcnt       <= '0;
            enable_o     <= 1'b0;
            half_tick_o  <= 1'b0;
            bit_tick_o   <= 1'b0;
            div_active_o <= 1'b0;
        end else if (load_i) begin
            dl_q         <= dl_i;
            dlf_q        <= dlf_i;
            osr_q        <= osr_i;
            cnt          <= (dl_i == '0) ? '0 : dl_i - ONE;
            subcnt       <= '0;
            enable_o     <= 1'b0;
            half_tick_o  <= 1'b0;
            bit_tick_o   <= 1'b0;
            div_active_o <= (dl_i != '0);
        end else begin
            enable_o     <= tick_due;
            half_tick_o  <= tick_due && !sync_i && (subcnt == half);
            bit_tick_o   <= tick_due && !sync_i && (subcnt == term);
            div_active_o <= (dl_q != '0);

            // dl_q - 1 + carry never exceeds dl_q, so the reload cannot wrap.
            if (tick_due) begin
                cnt <= dl_q - ONE + DL_W'(carry);
            end else if (cnt != '0) begin
                cnt <= cnt - ONE;
            end

            if (sync_i) begin
                subcnt <= '0;
            end else if (tick_due) begin
                subcnt <= (subcnt == term) ? 4'd0 : subcnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/uart_frac_baudgen.md
UART_FRAC_BAUDGEN -- requirements
Module: uart_frac_baudgen

Interface
REQ-001 The block SHALL have parameter DL_W, 16, integer divisor width.
REQ-002 The block SHALL have parameter FRAC_W, 4, fractional divisor width; the fractional step is 1/2^FRAC_W.
REQ-003 The block SHALL have port clk input 1, sole clock; all state on rising edge.
REQ-004 The block SHALL have port wb_rst_i input 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port dl_i input DL_W, integer divisor DL.
REQ-006 The block SHALL have port dlf_i input FRAC_W, fractional divisor DLF.
REQ-007 The block SHALL have port osr_i input 1, oversampling mode: 0 = 16x, 1 = 8x.
REQ-008 The block SHALL have port load_i input 1, one-cycle strobe that latches dl_i, dlf_i and osr_i into shadow registers.
REQ-009 The block SHALL have port sync_i input 1, receiver start-bit resync strobe.
REQ-010 The block SHALL have port enable_o output 1, one-cycle sample tick for the transmitter and receiver.
REQ-011 The block SHALL have port half_tick_o output 1, one-cycle mid-bit tick.
REQ-012 The block SHALL have port bit_tick_o output 1, one-cycle end-of-bit tick.
REQ-013 The block SHALL have port div_active_o output 1, high when the shadow DL is not 0.

Function
REQ-014 The block SHALL drive all outputs from registers; no combinational input-to-output paths.
REQ-015 The block SHALL contain a down-counter cnt (DL_W bits) and a fraction accumulator acc (FRAC_W bits).
REQ-016 When shadow DL != 0 and cnt == 0, the block SHALL register enable_o=1 for one cycle, set acc <= (acc+DLF) mod 2^FRAC_W, and reload cnt <= DL-1+carry, where carry is the overflow of acc+DLF.
REQ-017 When cnt != 0, the block SHALL decrement cnt by 1 each cycle.
REQ-018 The average enable_o period SHALL be DL + DLF/2^FRAC_W cycles; each individual period SHALL be DL or DL+1 cycles.
REQ-019 On the load_i edge the block SHALL latch the shadows and set cnt <= dl_i-1, acc <= 0 and subcnt <= 0; the first enable_o SHALL follow exactly dl_i cycles after that edge.
REQ-020 The block SHALL treat dl_i=0 as divider stopped: no ticks, cnt and acc held at 0, div_active_o=0.
REQ-021 With DL=1 and DLF=0, the block SHALL hold enable_o continuously high.
REQ-022 The block SHALL count enable_o pulses in subcnt, modulo 16 (osr=0) or modulo 8 (osr=1).
REQ-023 On an enable_o where subcnt == 7 (16x) or 3 (8x), the block SHALL pulse half_tick_o in the same cycle as enable_o.
REQ-024 On an enable_o where subcnt == 15 (16x) or 7 (8x), the block SHALL pulse bit_tick_o and wrap subcnt to 0.
REQ-025 When sync_i=1, the block SHALL set subcnt <= 0 and suppress half_tick_o and bit_tick_o for that cycle; enable_o is unaffected.
REQ-026 A change of osr_i, dl_i or dlf_i without load_i SHALL have no effect.
REQ-027 When load_i and a due tick coincide, load_i SHALL win: no enable_o, half_tick_o or bit_tick_o in that cycle.
REQ-028 When load_i and sync_i coincide, load_i SHALL win.
REQ-029 A load_i during a period SHALL abort that period; no partial tick is emitted.

Reset
REQ-030 While wb_rst_i=1, the block SHALL hold shadow DL=0, DLF=0, osr=0 (16x), and cnt, acc and subcnt at 0.
REQ-031 While wb_rst_i=1, the block SHALL hold enable_o, half_tick_o, bit_tick_o and div_active_o at 0.
REQ-032 After reset the block SHALL stay idle until the first load_i with dl_i != 0.
REQ-033 A reset asserted mid-period SHALL abandon the period immediately with no trailing tick.

Structure
REQ-034 Package uart_baud_pkg SHALL hold the OSR_16=0 and OSR_8=1 constants, the default DL_W/FRAC_W values, and the subcnt terminal and half values per mode.
REQ-035 The block SHALL contain one sub-module, uart_frac_acc, holding acc and producing carry, with ports clk, wb_rst_i, clr, step, dlf and carry.
REQ-036 The block SHALL contain no other hierarchy.

Verification
REQ-037 Load DL=4, DLF=0, 16x -> enable_o every 4 cycles; half_tick_o 32 cycles after load; bit_tick_o every 64 cycles.
REQ-038 Load DL=4, DLF=8 (FRAC_W=4) -> periods alternate 4 and 5; exactly 16 enable_o in 72 cycles; bit_tick_o spacing 72.
REQ-039 Load DL=1, DLF=0, 8x -> enable_o constantly high; bit_tick_o every 8 cycles; half_tick_o 4 cycles before each bit_tick_o.
REQ-040 Load DL=0 -> no ticks for 1000 cycles; div_active_o=0; then load DL=3 -> first enable_o 3 cycles later.
REQ-041 Load DL=100, then load DL=10 at cycle 50 -> no tick from the aborted period; next enable_o exactly 10 cycles after the second load.
REQ-042 Assert sync_i together with the enable_o at subcnt=15 -> no bit_tick_o that cycle; next bit_tick_o 16 enables later.
REQ-043 Assert wb_rst_i mid-period -> all outputs 0 immediately and idle after release.
